// File: rtl/bf_mem_pkg.sv
// Shared encodings for the brainfuck core's tape memory.
package bf_mem_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    localparam int unsigned RD_OLD = 0;
    localparam int unsigned RD_NEW = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// Sequential zero-sweep engine: walks every address once, one word per cycle.
module ram_clear_seq
    import bf_mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_rq,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam clr_state_t  RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    clr_state_t state;
    clr_state_t state_next;
    logic       last;

    assign last   = (clr_addr == ADDR_W'(DEPTH - 1));
    assign busy   = (state == ST_CLEAR);
    assign clr_we = (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RST_STATE;
        end else begin
            state <= state_next;
        end
    end

    // clear_rq is only looked at in IDLE, so a request mid-sweep has no effect
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (clear_rq) state_next = ST_CLEAR;
            ST_CLEAR: if (last)     state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Wraps back to 0 naturally after the last word
    always_ff @(posedge clk) begin
        if (!reset) begin
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/ram_dual_port_clr.sv
// Simple-dual-port tape RAM with a registered read port and a sequential clear engine.
module ram_dual_port_clr
    import bf_mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned RD_MODE        = RD_OLD,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_rq,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              port_ok;
    logic              wr_go;
    logic              rd_go;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              bypass;

    ram_clear_seq #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clear_rq (clear_rq),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy)
    );

    // A pending clear request outranks both user ports in the same cycle
    assign port_ok = !busy && !clear_rq;
    assign wr_go   = port_ok && wr_en;
    assign rd_go   = port_ok && rd_en;

    assign mem_we   = reset && (clr_we || wr_go);
    assign mem_addr = clr_we ? clr_addr : wr_addr;
    assign mem_data = clr_we ? '0 : wr_data;

    assign bypass = (RD_MODE == RD_NEW) && wr_go && (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_go;
            if (rd_go) begin
                rd_data <= bypass ? wr_data : mem[rd_addr];
            end
        end
    end

endmodule
